// File: rtl/dec_key_sequencer.sv
// -----------------------------------------------------------------------------
// dec_key_sequencer
// Anubis-128 style decryption round-key sequencer (N=4, R=12, 13 round keys).
// A start in IDLE loads the cipher key. EXPAND runs the forward key schedule for
// 13 cycles and fills a 13-entry encryption-key buffer E_0..E_12. DELIVER then
// streams the decryption keys D_0..D_12 (D_i from E_(12-i)) over a valid/ready
// handshake.
//
// Key-schedule primitives on a 4x4 byte state. Byte k=4*row+col sits at bits
// [127-8k -: 8].
//   gamma : bytewise S-box, with s(x) = {P(x[3:0]), P(x[7:4])}
//   pi    : column j rotated down by j rows
//   theta : each row times the GF(2^8) Hadamard matrix had(01,02,04,06),
//           using polynomial x^8+x^4+x^3+x^2+1
//   sigma : round constant c_r XORed into row 0, where c_r[j] = s(4(r-1)+j)
//   tau   : transpose
//   Psi(K,c_r) = sigma_r(theta(pi(gamma(K))))
//   Fi(K)      = tau(theta(gamma(K)))
//
// Optional feature: define DEC_THETA_EN to apply theta to D_1..D_11 on the
// buffer read path. This serves the equivalent inverse-cipher structure.
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   rst        : synchronous, active-high reset
//   start      : one-cycle request; accepted only in IDLE
//   key_in     : 128-bit cipher key, sampled on an accepted start
//   key_ready  : consumer ready
//   round_key  : current decryption round key (0 while key_valid=0)
//   key_valid  : round_key is valid
//   key_idx    : decryption round index 0..12
//   busy       : high in EXPAND and DELIVER
//   done       : one-cycle pulse after the key_idx 12 handshake
// -----------------------------------------------------------------------------
module dec_key_sequencer (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         key_ready,
  output logic [127:0] round_key,
  output logic         key_valid,
  output logic [3:0]   key_idx,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DELIVER} state_e;

  localparam logic [3:0] LAST = 4'd12;

  // ---------------------------------------------------------------------------
  // Key-schedule primitives
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] mini_sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return {mini_sbox(x[3:0]), mini_sbox(x[7:4])};
  endfunction

  // Multiply by x modulo x^8+x^4+x^3+x^2+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
  endfunction

  function automatic logic [127:0] gamma_f(input logic [127:0] v);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = sbox(v[127-8*k -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] pi_f(input logic [127:0] v);
    logic [127:0] o;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        o[127-8*(4*i+j) -: 8] = v[127-8*(4*((i-j+4)%4)+j) -: 8];
    return o;
  endfunction

  // Row times had(01,02,04,06). The matrix entry H[j][k] is h[j^k].
  function automatic logic [127:0] theta_f(input logic [127:0] v);
    logic [127:0] o;
    logic [7:0]   x;
    logic [7:0]   acc;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          x = v[127-8*(4*i+j) -: 8];
          case (2'(j ^ k))
            2'd0:    acc = acc ^ x;
            2'd1:    acc = acc ^ xtime(x);
            2'd2:    acc = acc ^ xtime(xtime(x));
            default: acc = acc ^ xtime(xtime(x)) ^ xtime(x);
          endcase
        end
        o[127-8*(4*i+k) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] tau_f(input logic [127:0] v);
    logic [127:0] o;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        o[127-8*(4*i+j) -: 8] = v[127-8*(4*j+i) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] sigma_f(input logic [127:0] v, input logic [3:0] r);
    logic [127:0] o;
    o = v;
    for (int j = 0; j < 4; j++)
      o[127-8*j -: 8] = v[127-8*j -: 8] ^ sbox({2'b00, r - 4'd1, 2'(j)});
    return o;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e       state_q, state_d;
  logic [127:0] k_q, k_d;
  logic [3:0]   r_q, r_d;
  logic [3:0]   idx_q, idx_d;
  logic         done_q, done_d;
  logic         buf_we;
  logic [127:0] ebuf_q [13];

  logic [127:0] psi_k;
  logic [127:0] new_e;
  logic [127:0] rd_key;
  logic [127:0] dec_key;

  // On cycle r=0, E_0 is extracted from K itself. On later cycles it is taken
  // from the evolved key.
  assign psi_k = sigma_f(theta_f(pi_f(gamma_f(k_q))), r_q);
  assign new_e = tau_f(theta_f(gamma_f((r_q == 4'd0) ? k_q : psi_k)));

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    state_d = state_q;
    k_d     = k_q;
    r_d     = r_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    buf_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d     = key_in;
          r_d     = 4'd0;
          idx_d   = 4'd0;
          state_d = S_EXPAND;
        end
      end
      S_EXPAND: begin
        buf_we = 1'b1;
        if (r_q != 4'd0) k_d = psi_k;
        if (r_q == LAST) begin
          idx_d   = 4'd0;
          state_d = S_DELIVER;
        end else begin
          r_d = r_q + 4'd1;
        end
      end
      S_DELIVER: begin
        if (key_ready) begin
          if (idx_q == LAST) begin
            idx_d   = 4'd0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      r_q     <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      r_q     <= r_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // NOTE: the key buffer has no reset. Every entry is rewritten during EXPAND
  // before DELIVER can read it, and the output is gated while key_valid=0.
  always_ff @(posedge clk) begin
    if (buf_we) ebuf_q[r_q] <= new_e;
  end

  // ---------------------------------------------------------------------------
  // Read path: D_i comes from E_(12-i), with no added latency.
  // ---------------------------------------------------------------------------
  assign rd_key = ebuf_q[LAST - idx_q];

`ifdef DEC_THETA_EN
  assign dec_key = (idx_q == 4'd0 || idx_q == LAST) ? rd_key : theta_f(rd_key);
`else
  assign dec_key = rd_key;
`endif

  assign key_valid = (state_q == S_DELIVER);
  assign busy      = (state_q != S_IDLE);
  assign key_idx   = idx_q;
  assign done      = done_q;
  assign round_key = key_valid ? dec_key : '0;

endmodule
